// File: rtl/atm_txn_ctrl.sv
// ATM transaction sequencer: PIN check, menu, amount entry and digit-serial BCD
// deposit/withdraw against a packed-BCD balance, with lockout and idle timeout.
module atm_txn_ctrl #(
  parameter logic [31:0] PIN         = 32'h0000_1234,
  parameter logic [31:0] INIT_BAL    = 32'h0000_5000,
  parameter int          MAX_TRIES   = 3,
  parameter int          TIMEOUT_CYC = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        confirm_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] entry_i,
  output logic [31:0] balance_o,
  output logic [31:0] disp_o,
  output logic [2:0]  state_o,
  output logic [1:0]  err_o,
  output logic        locked_o,
  output logic        busy_o,
  output logic        entry_clr_o
);

  typedef enum logic [2:0] {
    ST_PIN    = 3'd0,
    ST_MENU   = 3'd1,
    ST_AMOUNT = 3'd2,
    ST_CALC   = 3'd3,
    ST_LOCK   = 3'd4
  } state_t;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [2:0]  TRIES    = 3'(MAX_TRIES);

  state_t      state, state_nx;
  logic        confirm_q, cnf, acc_cnf, idle_st, tmo_hit, pin_ok, bad_bcd;
  logic        op_wd, carry, dig_c;
  logic [2:0]  fails, fails_inc, idx;
  logic [31:0] tmo_cnt, amount;
  logic [27:0] acc;
  logic [3:0]  dig_a, dig_b, dig_out;
  logic [4:0]  dig_sum;

  assign cnf       = confirm_i & ~confirm_q;
  assign acc_cnf   = cnf & ((state == ST_PIN) || (state == ST_MENU) || (state == ST_AMOUNT));
  assign idle_st   = (state == ST_MENU) || (state == ST_AMOUNT);
  assign tmo_hit   = idle_st && (tmo_cnt == TMO_LAST);
  assign pin_ok    = (entry_i == PIN);
  assign fails_inc = fails + 3'd1;

  always_comb begin
    bad_bcd = 1'b0;
    for (int i = 0; i < 8; i++)
      if (entry_i[i*4 +: 4] > 4'd9) bad_bcd = 1'b1;
  end

  // One BCD digit of balance +/- amount per cycle; dig_c is carry (add) or borrow (sub).
  always_comb begin
    dig_a = balance_o[{idx, 2'b00} +: 4];
    dig_b = amount[{idx, 2'b00} +: 4];
    if (op_wd) begin
      dig_sum = {1'b0, dig_a} - {1'b0, dig_b} - {4'd0, carry};
      dig_c   = dig_sum[4];
      dig_out = dig_c ? dig_sum[3:0] + 4'd10 : dig_sum[3:0];
    end else begin
      dig_sum = {1'b0, dig_a} + {1'b0, dig_b} + {4'd0, carry};
      dig_c   = (dig_sum > 5'd9);
      dig_out = dig_c ? dig_sum[3:0] + 4'd6 : dig_sum[3:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_PIN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_PIN:
        if (cnf) begin
          if (pin_ok)                  state_nx = ST_MENU;
          else if (fails_inc >= TRIES) state_nx = ST_LOCK;
        end
      ST_MENU:
        if (cnf) begin
          if (op_i == 2'b01 || op_i == 2'b10) state_nx = ST_AMOUNT;
          else if (op_i == 2'b11)             state_nx = ST_PIN;
        end else if (tmo_hit) state_nx = ST_PIN;
      ST_AMOUNT:
        if (cnf)          state_nx = bad_bcd ? ST_MENU : ST_CALC;
        else if (tmo_hit) state_nx = ST_PIN;
      ST_CALC:
        if (idx == 3'd7) state_nx = ST_MENU;
      ST_LOCK: state_nx = ST_LOCK;
      default: state_nx = ST_PIN;
    endcase
  end

  always_comb begin
    state_o  = state;
    locked_o = (state == ST_LOCK);
    busy_o   = (state == ST_CALC);
  end

  // Datapath: fail count, idle timer, operand latches, BCD accumulator and commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      confirm_q   <= 1'b0;
      entry_clr_o <= 1'b0;
      disp_o      <= 32'd0;
      balance_o   <= INIT_BAL;
      err_o       <= 2'b00;
      fails       <= 3'd0;
      tmo_cnt     <= 32'd0;
      op_wd       <= 1'b0;
      amount      <= 32'd0;
      acc         <= 28'd0;
      idx         <= 3'd0;
      carry       <= 1'b0;
    end else begin
      confirm_q   <= confirm_i;
      entry_clr_o <= acc_cnf;

      case (state)
        ST_PIN, ST_AMOUNT: disp_o <= entry_i;
        ST_MENU, ST_CALC:  disp_o <= balance_o;
        default:           disp_o <= 32'hFFFF_FFFF;
      endcase

      if (!idle_st || acc_cnf || (state_nx != state)) tmo_cnt <= 32'd0;
      else                                           tmo_cnt <= tmo_cnt + 32'd1;

      case (state)
        ST_PIN:
          if (cnf) begin
            err_o <= pin_ok ? 2'b00 : 2'b01;
            fails <= pin_ok ? 3'd0 : fails_inc;
          end
        ST_MENU:
          if (cnf) begin
            err_o <= 2'b00;
            if (op_i == 2'b01 || op_i == 2'b10) op_wd <= op_i[1];
            if (op_i == 2'b11) fails <= 3'd0;
          end else if (tmo_hit) fails <= 3'd0;
        ST_AMOUNT:
          if (cnf) begin
            if (bad_bcd) err_o <= 2'b11;
            else begin
              err_o  <= 2'b00;
              amount <= entry_i;
              idx    <= 3'd0;
              carry  <= 1'b0;
            end
          end else if (tmo_hit) fails <= 3'd0;
        ST_CALC: begin
          acc   <= {dig_out, acc[27:4]};
          carry <= dig_c;
          idx   <= idx + 3'd1;
          // Final digit: a carry/borrow out of digit 7 rejects the whole result.
          if (idx == 3'd7) begin
            if (dig_c) err_o     <= op_wd ? 2'b10 : 2'b11;
            else       balance_o <= {dig_out, acc};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_txn_ctrl.sv
// Self-checking bench for atm_txn_ctrl: directed corner sequences, a transaction
// table with hand-computed results, and random transactions against a decimal model.
module tb_atm_txn_ctrl;

  localparam logic [31:0] PIN_V  = 32'h0000_1234;
  localparam logic [31:0] INIT_V = 32'h0000_5000;
  localparam int          TMO    = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        confirm_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] entry_i = 32'd0;
  logic [31:0] balance_o, disp_o;
  logic [2:0]  state_o;
  logic [1:0]  err_o;
  logic        locked_o, busy_o, entry_clr_o;

  atm_txn_ctrl #(
    .PIN(PIN_V), .INIT_BAL(INIT_V), .MAX_TRIES(3), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .confirm_i(confirm_i), .op_i(op_i), .entry_i(entry_i),
    .balance_o(balance_o), .disp_o(disp_o), .state_o(state_o), .err_o(err_o),
    .locked_o(locked_o), .busy_o(busy_o), .entry_clr_o(entry_clr_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] amt;
    logic [31:0] exp_bal;
    logic [1:0]  exp_err;
    int          exp_busy;
  } vec_t;

  vec_t tbl[13];

  longint m_bal;
  logic [1:0] m_err;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] to_bcd(input longint v);
    logic [31:0] r;
    longint t;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic longint from_bcd(input logic [31:0] b);
    longint v;
    v = 0;
    for (int i = 7; i >= 0; i--) v = v * 10 + longint'(b[i*4 +: 4]);
    return v;
  endfunction

  function automatic bit bcd_ok(input logic [31:0] b);
    for (int i = 0; i < 8; i++)
      if (b[i*4 +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  task automatic pressConfirm();
    @(posedge clk); #1 confirm_i = 1'b1;
    @(posedge clk); #1 confirm_i = 1'b0;
  endtask

  // Menu op from MENU; deposit/withdraw also enter the amount and wait out CALC.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] amt, output int busy_cycles);
    busy_cycles = 0;
    op_i = op;
    pressConfirm();
    if (op == 2'b01 || op == 2'b10) begin
      entry_i = amt;
      pressConfirm();
      while (busy_o === 1'b1 && busy_cycles < 20) begin
        busy_cycles++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic doReset();
    @(posedge clk); #1 rst = 1'b1;
    #1;
    checkOutput("rst_state", 32'(state_o), 32'd0);
    checkOutput("rst_balance", balance_o, INIT_V);
    checkOutput("rst_disp", disp_o, 32'd0);
    checkOutput("rst_err", 32'(err_o), 32'd0);
    checkOutput("rst_flags", {29'd0, locked_o, busy_o, entry_clr_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic login();
    entry_i = PIN_V;
    pressConfirm();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bc;
    logic [1:0] op;
    logic [31:0] amt;
    longint v;

    tbl[0]  = '{2'b10, 32'h0000_9999, 32'h0000_5000, 2'b10, 8};
    tbl[1]  = '{2'b01, 32'h0000_4999, 32'h0000_9999, 2'b00, 8};
    tbl[2]  = '{2'b10, 32'h0000_4999, 32'h0000_5000, 2'b00, 8};
    tbl[3]  = '{2'b10, 32'h0000_5000, 32'h0000_0000, 2'b00, 8};
    tbl[4]  = '{2'b01, 32'h0000_0000, 32'h0000_0000, 2'b00, 8};
    tbl[5]  = '{2'b01, 32'h9999_9990, 32'h9999_9990, 2'b00, 8};
    tbl[6]  = '{2'b01, 32'h0000_0010, 32'h9999_9990, 2'b11, 8};
    tbl[7]  = '{2'b00, 32'h0000_0000, 32'h9999_9990, 2'b00, 0};
    tbl[8]  = '{2'b01, 32'h0000_000A, 32'h9999_9990, 2'b11, 0};
    tbl[9]  = '{2'b10, 32'h9999_9991, 32'h9999_9990, 2'b10, 8};
    tbl[10] = '{2'b10, 32'h0000_0001, 32'h9999_9989, 2'b00, 8};
    tbl[11] = '{2'b01, 32'h0000_0011, 32'h9999_9989, 2'b11, 8};
    tbl[12] = '{2'b10, 32'h9999_9989, 32'h0000_0000, 2'b00, 8};

    doReset();

    // Correct PIN, then display follows balance one cycle later.
    login();
    checkOutput("pin_ok_state", 32'(state_o), 32'd1);
    checkOutput("pin_ok_err", 32'(err_o), 32'd0);
    checkOutput("pin_ok_clr", 32'(entry_clr_o), 32'd1);
    @(posedge clk); #1;
    checkOutput("pin_ok_clr_off", 32'(entry_clr_o), 32'd0);
    checkOutput("pin_ok_disp", disp_o, 32'h0000_5000);
    applyStimulus(2'b11, 32'd0, bc);
    checkOutput("logout_state", 32'(state_o), 32'd0);

    // Three wrong PINs lock the machine.
    for (int i = 0; i < 3; i++) begin
      entry_i = 32'h0000_1111;
      pressConfirm();
      checkOutput("bad_pin_err", 32'(err_o), 32'd1);
      checkOutput("bad_pin_state", 32'(state_o), (i < 2) ? 32'd0 : 32'd4);
    end
    checkOutput("lock_flag", 32'(locked_o), 32'd1);
    @(posedge clk); #1;
    checkOutput("lock_disp", disp_o, 32'hFFFF_FFFF);
    login();
    checkOutput("lock_ignore_state", 32'(state_o), 32'd4);
    checkOutput("lock_ignore_clr", 32'(entry_clr_o), 32'd0);
    checkOutput("lock_ignore_err", 32'(err_o), 32'd1);
    doReset();

    // Fail count clears on a correct PIN.
    for (int i = 0; i < 2; i++) begin
      entry_i = 32'h0000_0000;
      pressConfirm();
    end
    login();
    checkOutput("fails_clr_err", 32'(err_o), 32'd0);
    applyStimulus(2'b11, 32'd0, bc);
    for (int i = 0; i < 2; i++) begin
      entry_i = 32'h0000_4321;
      pressConfirm();
    end
    checkOutput("fails_clr_state", 32'(state_o), 32'd0);
    checkOutput("fails_clr_lock", 32'(locked_o), 32'd0);
    login();
    checkOutput("relogin_state", 32'(state_o), 32'd1);

    // Transaction table from the reset balance.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].op, tbl[i].amt, bc);
      checkOutput($sformatf("tbl%0d_busy", i), 32'(bc), 32'(tbl[i].exp_busy));
      checkOutput($sformatf("tbl%0d_bal", i), balance_o, tbl[i].exp_bal);
      checkOutput($sformatf("tbl%0d_err", i), 32'(err_o), 32'(tbl[i].exp_err));
      checkOutput($sformatf("tbl%0d_state", i), 32'(state_o), 32'd1);
    end

    // Idle timeout from MENU keeps the error code.
    applyStimulus(2'b01, 32'h0000_00B0, bc);
    checkOutput("tmo_menu_err_pre", 32'(err_o), 32'd3);
    repeat (TMO - 1) @(posedge clk);
    #1 checkOutput("tmo_menu_before", 32'(state_o), 32'd1);
    @(posedge clk); #1;
    checkOutput("tmo_menu_after", 32'(state_o), 32'd0);
    checkOutput("tmo_menu_err", 32'(err_o), 32'd3);

    // Idle timeout from AMOUNT.
    login();
    op_i = 2'b01;
    pressConfirm();
    repeat (TMO - 1) @(posedge clk);
    #1 checkOutput("tmo_amt_before", 32'(state_o), 32'd2);
    @(posedge clk); #1;
    checkOutput("tmo_amt_after", 32'(state_o), 32'd0);

    // Confirm on the last idle cycle wins, then reset mid-CALC discards it.
    login();
    op_i = 2'b01;
    pressConfirm();
    entry_i = 32'h0000_0123;
    repeat (TMO - 1) @(posedge clk);
    #1 confirm_i = 1'b1;
    @(posedge clk); #1 confirm_i = 1'b0;
    checkOutput("tmo_cnf_wins", 32'(state_o), 32'd3);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_calc_rst_state", 32'(state_o), 32'd0);
    checkOutput("mid_calc_rst_bal", balance_o, INIT_V);
    checkOutput("mid_calc_rst_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Random transactions against the decimal model.
    m_bal = 5000;
    login();
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0:       op = 2'b00;
        1:       op = 2'b11;
        2, 3, 4: op = 2'b01;
        default: op = 2'b10;
      endcase
      case ($urandom_range(0, 3))
        0: v = longint'($urandom_range(0, 999));
        1: begin
          v = m_bal + longint'($urandom_range(0, 2)) - 1;
          if (v < 0) v = 0;
          if (v > 99999999) v = 99999999;
        end
        2: v = longint'($urandom_range(0, 99999999));
        default: v = -1;
      endcase
      if (v < 0) begin
        amt = to_bcd(longint'($urandom_range(0, 99999999)));
        amt[$urandom_range(0, 7) * 4 +: 4] = 4'($urandom_range(10, 15));
      end else amt = to_bcd(v);

      applyStimulus(op, amt, bc);
      if (op == 2'b01 || op == 2'b10) begin
        if (!bcd_ok(amt)) begin
          m_err = 2'b11;
          checkOutput("rnd_busy_bad", 32'(bc), 32'd0);
        end else begin
          checkOutput("rnd_busy", 32'(bc), 32'd8);
          if (op == 2'b01) begin
            if (m_bal + from_bcd(amt) > 99999999) m_err = 2'b11;
            else begin m_bal = m_bal + from_bcd(amt); m_err = 2'b00; end
          end else begin
            if (from_bcd(amt) > m_bal) m_err = 2'b10;
            else begin m_bal = m_bal - from_bcd(amt); m_err = 2'b00; end
          end
        end
      end else m_err = 2'b00;

      checkOutput("rnd_bal", balance_o, to_bcd(m_bal));
      checkOutput("rnd_err", 32'(err_o), 32'(m_err));
      checkOutput("rnd_state", 32'(state_o), (op == 2'b11) ? 32'd0 : 32'd1);

      if (op == 2'b11) begin
        if ($urandom_range(0, 1) == 1) begin
          entry_i = to_bcd(longint'($urandom_range(0, 99999999)));
          if (entry_i == PIN_V) entry_i = 32'd0;
          pressConfirm();
          checkOutput("rnd_badpin_err", 32'(err_o), 32'd1);
          checkOutput("rnd_badpin_state", 32'(state_o), 32'd0);
        end
        login();
        checkOutput("rnd_login_state", 32'(state_o), 32'd1);
        checkOutput("rnd_login_err", 32'(err_o), 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
